deserializer_rx: RTL and testbench



---
 rtl/deser_pkg.sv | 9 +
 rtl/deser_bit_timer.sv | 40 ++++
 rtl/deserializer_rx.sv | 68 ++++++
 tb/tb_deserializer_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// deser_pkg: shared state type, width helper and default sizing for the serial receiver.
package deser_pkg;
    typedef enum logic {IDLE, RUN} state_e;
    localparam int DESER_DIV   = 4;
    localparam int DESER_WIDTH = 8;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/deser_bit_timer.sv
// deser_bit_timer: slot-phase counter and slot index producing the sample strobe.
module deser_bit_timer
    import deser_pkg::*;
#(
    parameter int DIV       = DESER_DIV,
    parameter int WIDTH     = DESER_WIDTH,
    parameter int SAMPLE_PT = (DIV - 1) / 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic align,
    output logic strobe,
    output logic sel,
    output logic last
);
    localparam int CW = clog2_min1(DIV);
    localparam int KW = clog2_min1(2 * WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;

    always_comb begin
        strobe = run && !align && cnt_q == CW'(SAMPLE_PT);
        sel    = k_q[0];
        last   = k_q == KW'(2 * WIDTH - 1);
        cnt_d  = align ? '0 : !run ? cnt_q : (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        k_d    = align ? '0 : !strobe ? k_q : last ? '0 : k_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end
endmodule

// File: rtl/deserializer_rx.sv
// deserializer_rx: recovers two interleaved MSB-first channel words from an oversampled serial stream.
module deserializer_rx
    import deser_pkg::*;
#(
    parameter int DIV       = DESER_DIV,
    parameter int WIDTH     = DESER_WIDTH,
    parameter int SAMPLE_PT = (DIV - 1) / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_dataIn,
    input  logic             io_align,
    output logic [WIDTH-1:0] io_dataOut1,
    output logic [WIDTH-1:0] io_dataOut2,
    output logic             io_valid,
    output logic             io_locked
);
    state_e state_q, state_d;
    logic [WIDTH-1:0] sh1_q, sh1_d, sh2_q, sh2_d, out1_q, out1_d, out2_q, out2_d;
    logic valid_q, valid_d, locked_q, locked_d;
    logic strobe, sel, last;

    deser_bit_timer #(.DIV(DIV), .WIDTH(WIDTH), .SAMPLE_PT(SAMPLE_PT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == RUN),
        .align  (io_align),
        .strobe (strobe),
        .sel    (sel),
        .last   (last)
    );

    // Outputs load from the next-state shifters so the final sampled bit lands with io_valid.
    always_comb begin
        state_d  = io_align ? RUN : state_q;
        locked_d = locked_q | io_align;
        sh1_d    = io_align ? '0 : (strobe && !sel) ? WIDTH'({sh1_q, io_dataIn}) : sh1_q;
        sh2_d    = io_align ? '0 : (strobe && sel) ? WIDTH'({sh2_q, io_dataIn}) : sh2_q;
        valid_d  = strobe && last;
        out1_d   = valid_d ? sh1_d : out1_q;
        out2_d   = valid_d ? sh2_d : out2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sh1_q    <= '0;
            sh2_q    <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign io_dataOut1 = out1_q;
    assign io_dataOut2 = out2_q;
    assign io_valid    = valid_q;
    assign io_locked   = locked_q;
endmodule

// File: tb/tb_deserializer_rx.sv
// tb_deserializer_rx: scoreboard bench for DIV=4/WIDTH=8 and DIV=1/WIDTH=4 receivers.
module tb_deserializer_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din_a = 1'b0, al_a = 1'b0, din_b = 1'b0, al_b = 1'b0;
    logic [7:0] o1_a, o2_a;
    logic [3:0] o1_b, o2_b;
    logic v_a, lk_a, v_b, lk_b;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          t;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    deserializer_rx #(.DIV(4), .WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .io_dataIn(din_a), .io_align(al_a),
        .io_dataOut1(o1_a), .io_dataOut2(o2_a), .io_valid(v_a), .io_locked(lk_a)
    );

    deserializer_rx #(.DIV(1), .WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .io_dataIn(din_b), .io_align(al_b),
        .io_dataOut1(o1_b), .io_dataOut2(o2_b), .io_valid(v_b), .io_locked(lk_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v_a === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_valid", 32'(v_a), 32'd0);
            else begin
                ea = qa.pop_front();
                check("a_valid_cycle", cyc, ea.t);
                check("a_out1", 32'(o1_a), ea.a);
                check("a_out2", 32'(o2_a), ea.b);
            end
        end
        if (v_b === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_valid", 32'(v_b), 32'd0);
            else begin
                eb = qb.pop_front();
                check("b_valid_cycle", cyc, eb.t);
                check("b_out1", 32'(o1_b), eb.a);
                check("b_out2", 32'(o2_b), eb.b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input bit which, output int t);
        if (which) al_b = 1'b1; else al_a = 1'b1;
        t = cyc;
        tick();
        if (which) al_b = 1'b0; else al_a = 1'b0;
    endtask

    task automatic send_slots(input bit which, input logic [31:0] a, input logic [31:0] b,
                              input int w, input int div, input int n);
        logic bv;
        for (int k = 0; k < n; k++) begin
            bv = (k % 2 == 0) ? a[w-1-k/2] : b[w-1-k/2];
            if (which) din_b = bv; else din_a = bv;
            repeat (div) tick();
        end
    endtask

    task automatic push_a(input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t e;
        e.a = a; e.b = b; e.t = t;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t e;
        e.a = a; e.b = b; e.t = t;
        qb.push_back(e);
    endtask

    task automatic toggle_idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_a = i[0];
            din_b = ~i[1];
            tick();
        end
    endtask

    initial begin
        int t, t2;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_out1", 32'(o1_a), 32'h0);
        check("rst_out2", 32'(o2_a), 32'h0);
        check("rst_valid", 32'(v_a), 32'h0);
        check("rst_locked_a", 32'(lk_a), 32'h0);
        check("rst_locked_b", 32'(lk_b), 32'h0);

        toggle_idle(40);
        check("noalign_locked", 32'(lk_a), 32'h0);
        check("noalign_out1", 32'(o1_a), 32'h0);
        check("noalign_out2", 32'(o2_a), 32'h0);

        // back-to-back frames after one align; frame period 64 cycles
        begin_frame(0, t);
        push_a(32'hA5, 32'h3C, t + 63);
        push_a(32'h01, 32'h80, t + 127);
        push_a(32'hFF, 32'h00, t + 191);
        check("locked_after_align", 32'(lk_a), 32'h1);
        send_slots(0, 32'hA5, 32'h3C, 8, 4, 16);
        send_slots(0, 32'h01, 32'h80, 8, 4, 16);
        send_slots(0, 32'hFF, 32'h00, 8, 4, 16);
        al_a = 1'b1;
        tick();

        // realign 30 cycles into a frame
        begin_frame(0, t);
        send_slots(0, 32'h12, 32'h34, 8, 4, 7);
        tick();
        check("held_out1", 32'(o1_a), 32'hFF);
        check("held_out2", 32'(o2_a), 32'h00);
        begin_frame(0, t2);
        check("realign_offset", t2 - t, 32'd30);
        push_a(32'h5A, 32'hC3, t2 + 63);
        send_slots(0, 32'h5A, 32'hC3, 8, 4, 16);
        al_a = 1'b1;
        tick();

        // realign on the sample-strobe cycle of slot 3
        begin_frame(0, t);
        send_slots(0, 32'h11, 32'h22, 8, 4, 3);
        din_a = 1'b1;
        tick();
        begin_frame(0, t2);
        push_a(32'h69, 32'h96, t2 + 63);
        send_slots(0, 32'h69, 32'h96, 8, 4, 16);
        al_a = 1'b1;
        tick();

        // realign on the io_valid cycle
        begin_frame(0, t);
        push_a(32'hC6, 32'h39, t + 63);
        send_slots(0, 32'hC6, 32'h39, 8, 4, 15);
        din_a = 1'b1;
        repeat (2) tick();
        check("valid_at_realign", 32'(v_a), 32'h1);
        begin_frame(0, t2);
        push_a(32'h0F, 32'hF0, t2 + 63);
        send_slots(0, 32'h0F, 32'hF0, 8, 4, 16);
        al_a = 1'b1;

        // align held every cycle
        toggle_idle(50);
        check("hold_locked", 32'(lk_a), 32'h1);
        check("hold_out1", 32'(o1_a), 32'h0F);
        check("hold_out2", 32'(o2_a), 32'hF0);

        // DIV=1, WIDTH=4
        begin_frame(1, t);
        push_b(32'h9, 32'h6, t + 9);
        push_b(32'h3, 32'hC, t + 17);
        send_slots(1, 32'h9, 32'h6, 4, 1, 8);
        send_slots(1, 32'h3, 32'hC, 4, 1, 8);
        al_b = 1'b1;
        tick();

        // async reset during an io_valid cycle
        al_a = 1'b0;
        begin_frame(0, t);
        send_slots(0, 32'hAA, 32'h55, 8, 4, 15);
        din_a = 1'b1;
        repeat (2) tick();
        check("pre_reset_valid", 32'(v_a), 32'h1);
        check("pre_reset_out1", 32'(o1_a), 32'hAA);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(v_a), 32'h0);
        check("async_rst_out1", 32'(o1_a), 32'h0);
        check("async_rst_out2", 32'(o2_a), 32'h0);
        check("async_rst_locked", 32'(lk_a), 32'h0);
        tick();
        reset = 1'b0;
        al_a = 1'b0;
        al_b = 1'b0;
        toggle_idle(80);
        check("post_rst_locked", 32'(lk_a), 32'h0);
        check("post_rst_out1", 32'(o1_a), 32'h0);
        check("post_rst_out2", 32'(o2_a), 32'h0);

        check("a_pending", qa.size(), 32'd0);
        check("b_pending", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
